rename_table: RTL
=================

Name: rename_table

Overview:
- Speculative register alias table (RAT) plus architectural RAT for the rename stage.
- Sits between decode and dispatch. Consumes physical registers supplied by the free list, and returns each displaced old mapping to the ROB so commit can later free it.
- Resolves intra-group dependencies between lanes renamed in the same cycle.
- Restores speculative state from architectural state on a pipeline flush.

Parameters:
- PHYS_REG_NUM, 192, number of physical registers; PW = $clog2(PHYS_REG_NUM).
- ARCH_REG_NUM, 32, number of architectural registers; AW = $clog2(ARCH_REG_NUM).
- RENAME_WIDTH, 6, instructions renamed per cycle.
- COMMIT_WIDTH, 6, instructions committed per cycle.

Ports:
- clk  in  1  clock
- a_rst_n  in  1  asynchronous reset, active low
- flush_i  in  1  pipeline flush: restore speculative RAT from architectural RAT
- rename_valid_i  in  RENAME_WIDTH  lane valid; set bits contiguous from [0]
- rs1_i, rs2_i  in  RENAME_WIDTH x AW  source architectural registers
- rd_i  in  RENAME_WIDTH x AW  destination architectural register
- rd_we_i  in  RENAME_WIDTH  lane writes rd
- rename_ready_o  out  1  group accepted this cycle
- can_alloc_i  in  1  free list can supply this cycle's allocation
- alloc_req_o  out  RENAME_WIDTH  allocation request to free list; set bits contiguous from [0]
- preg_i  in  RENAME_WIDTH x PW  free physical registers, compacted from slot 0
- commit_valid_i  in  COMMIT_WIDTH  committing lanes with a destination
- commit_rd_i  in  COMMIT_WIDTH x AW  committed architectural destination
- commit_pdst_i  in  COMMIT_WIDTH x PW  committed physical destination
- valid_o  out  RENAME_WIDTH  registered lane valid
- psrc1_o, psrc2_o  out  RENAME_WIDTH x PW  renamed sources
- pdst_o  out  RENAME_WIDTH x PW  new physical destination
- old_pdst_o  out  RENAME_WIDTH x PW  previous mapping of rd, sent to ROB for freeing at commit
- stall_cnt_o  out  32  rename stall cycle count (see optional feature)

Behaviour:
- Reset (async, a_rst_n low):
  - spec_rat[i] = arch_rat[i] = i for all i.
  - valid_o = 0; psrc1_o, psrc2_o, pdst_o, old_pdst_o = 0.
  - stall_cnt_o = 0.
- Effective write: w[i] = rename_valid_i[i] & rd_we_i[i] & (rd_i[i] != 0).
  - Architectural register 0 is never renamed; it always reads physical register 0.
- Handshake (combinational):
  - rename_ready_o = can_alloc_i & ~flush_i.
  - fire = rename_ready_o & rename_valid_i[0].
- Allocation compaction:
  - k[i] = number of set w[j] for j < i.
  - Lane i with w[i] takes preg_i[k[i]].
  - alloc_req_o[m] = fire & (m < popcount(w)).
- Source lookup, lane i:
  - Base value is spec_rat[rs].
  - Overridden by the new pdst of the highest lane j < i with w[j] and rd_j == rs.
  - rs == 0 always yields 0.
- old_pdst, lane i: same rule applied to rd_i (earlier same-group writer wins over the table).
- Speculative RAT update on fire:
  - spec_rat[rd_i] <= new pdst for each w[i].
  - Highest lane wins on duplicate rd.
- Output register, one-cycle latency:
  - On fire: valid_o <= rename_valid_i; all lane fields registered.
  - Otherwise: valid_o <= 0; data fields hold.
- Commit:
  - arch_rat[commit_rd_i[c]] <= commit_pdst_i[c] for each commit_valid_i[c] with rd != 0.
  - Highest lane wins on duplicate rd.
  - Commit is independent of fire and flush.
- Flush:
  - spec_rat <= next-state arch_rat, i.e. including the same cycle's commits.
  - valid_o <= 0; rename in that cycle is suppressed (ready = 0, no alloc).
- Stall: fire = 0 while valid is high → no state change except commits; outputs drop valid.
- Lane validity: non-contiguous rename_valid_i is illegal (assertion only).

Optional Feature:
- Macro: RENAME_STALL_CNT_EN.
- Defined:
  - stall_cnt_o increments (saturating at 2^32-1) each cycle with rename_valid_i[0] & ~can_alloc_i & ~flush_i.
  - Clears on reset.
- Undefined: stall_cnt_o tied to 0; no counter flops.

Test Plan:
- Reset, then lane0 rs1=5, rs2=0, rd=3, we, preg_i[0]=40 → next cycle: psrc1=5, psrc2=0, pdst=40, old_pdst=3, alloc_req_o=6'b000001.
- Lane0 rd=7 (preg 50); lane1 rs1=7, rd=7, we (preg 51); lane2 rs1=7, no write → lane1 psrc1=50, old_pdst=50; lane2 psrc1=51; spec_rat[7]=51 afterwards.
- Lane0 we=0, lanes 1 and 3 write rd=4 and rd=9 with preg_i={61,60} → lane1 pdst=60, lane3 pdst=61, alloc_req_o=6'b000011.
- can_alloc_i=0 with valid group → rename_ready_o=0, alloc_req_o=0, next valid_o=0, RAT unchanged; stall_cnt_o increments by 1 when RENAME_STALL_CNT_EN is defined.
- Rename rd=2→70, then flush_i together with commit rd=2, pdst=65 → spec_rat[2]=65; a following rename of rs1=2 yields psrc1=65.
- rd=0 with we=1 → no allocation, pdst not used, spec_rat unchanged; rs1=0 reads 0.

Source files
------------

// File: rtl/rename_table.sv
// Speculative + architectural register alias tables for the rename stage.
// Optional stall-cycle counter enabled by defining RENAME_STALL_CNT_EN.
module rename_table #(
    parameter int PHYS_REG_NUM = 192,
    parameter int ARCH_REG_NUM = 32,
    parameter int RENAME_WIDTH = 6,
    parameter int COMMIT_WIDTH = 6,
    localparam int PW = $clog2(PHYS_REG_NUM),
    localparam int AW = $clog2(ARCH_REG_NUM)
) (
    input  logic                             clk,
    input  logic                             a_rst_n,
    input  logic                             flush_i,
    input  logic [RENAME_WIDTH-1:0]          rename_valid_i,
    input  logic [RENAME_WIDTH-1:0][AW-1:0]  rs1_i,
    input  logic [RENAME_WIDTH-1:0][AW-1:0]  rs2_i,
    input  logic [RENAME_WIDTH-1:0][AW-1:0]  rd_i,
    input  logic [RENAME_WIDTH-1:0]          rd_we_i,
    output logic                             rename_ready_o,
    input  logic                             can_alloc_i,
    output logic [RENAME_WIDTH-1:0]          alloc_req_o,
    input  logic [RENAME_WIDTH-1:0][PW-1:0]  preg_i,
    input  logic [COMMIT_WIDTH-1:0]          commit_valid_i,
    input  logic [COMMIT_WIDTH-1:0][AW-1:0]  commit_rd_i,
    input  logic [COMMIT_WIDTH-1:0][PW-1:0]  commit_pdst_i,
    output logic [RENAME_WIDTH-1:0]          valid_o,
    output logic [RENAME_WIDTH-1:0][PW-1:0]  psrc1_o,
    output logic [RENAME_WIDTH-1:0][PW-1:0]  psrc2_o,
    output logic [RENAME_WIDTH-1:0][PW-1:0]  pdst_o,
    output logic [RENAME_WIDTH-1:0][PW-1:0]  old_pdst_o,
    output logic [31:0]                      stall_cnt_o
);
    localparam int CW = $clog2(RENAME_WIDTH + 1);

    logic [PW-1:0] spec_rat_q [ARCH_REG_NUM];
    logic [PW-1:0] spec_rat_d [ARCH_REG_NUM];
    logic [PW-1:0] arch_rat_q [ARCH_REG_NUM];
    logic [PW-1:0] arch_rat_d [ARCH_REG_NUM];

    logic [RENAME_WIDTH-1:0]         w;
    logic [RENAME_WIDTH-1:0][PW-1:0] new_pdst;
    logic [CW-1:0]                   n_alloc;
    logic                            fire;

    logic [RENAME_WIDTH-1:0][PW-1:0] psrc1_d, psrc2_d, old_pdst_d;
    logic [RENAME_WIDTH-1:0]         valid_q;
    logic [RENAME_WIDTH-1:0][PW-1:0] psrc1_q, psrc2_q, pdst_q, old_pdst_q;

    // Handshake: the group in rename_valid_i is consumed on a clock edge where
    // rename_ready_o && rename_valid_i[0]; the free list sees alloc_req_o only then.
    assign rename_ready_o = can_alloc_i & ~flush_i;
    assign fire           = rename_ready_o & rename_valid_i[0];

    // Writers take free registers in lane order from slot 0.
    always_comb begin
        n_alloc  = '0;
        w        = '0;
        new_pdst = '0;
        for (int i = 0; i < RENAME_WIDTH; i++) begin
            w[i] = rename_valid_i[i] & rd_we_i[i] & (rd_i[i] != '0);
            if (w[i]) begin
                new_pdst[i] = preg_i[n_alloc];
                n_alloc     = n_alloc + CW'(1);
            end
        end
    end

    always_comb begin
        alloc_req_o = '0;
        for (int m = 0; m < RENAME_WIDTH; m++)
            alloc_req_o[m] = fire & (CW'(m) < n_alloc);
    end

    // Later same-group writers override earlier ones and the table.
    always_comb begin
        psrc1_d    = '0;
        psrc2_d    = '0;
        old_pdst_d = '0;
        for (int i = 0; i < RENAME_WIDTH; i++) begin
            psrc1_d[i]    = spec_rat_q[rs1_i[i]];
            psrc2_d[i]    = spec_rat_q[rs2_i[i]];
            old_pdst_d[i] = spec_rat_q[rd_i[i]];
            for (int j = 0; j < i; j++) begin
                if (w[j] && rd_i[j] == rs1_i[i]) psrc1_d[i]    = new_pdst[j];
                if (w[j] && rd_i[j] == rs2_i[i]) psrc2_d[i]    = new_pdst[j];
                if (w[j] && rd_i[j] == rd_i[i])  old_pdst_d[i] = new_pdst[j];
            end
            if (rs1_i[i] == '0) psrc1_d[i]    = '0;
            if (rs2_i[i] == '0) psrc2_d[i]    = '0;
            if (rd_i[i] == '0)  old_pdst_d[i] = '0;
        end
    end

    always_comb begin
        arch_rat_d = arch_rat_q;
        for (int c = 0; c < COMMIT_WIDTH; c++)
            if (commit_valid_i[c] && commit_rd_i[c] != '0)
                arch_rat_d[commit_rd_i[c]] = commit_pdst_i[c];
    end

    // Flush restores from the post-commit architectural state.
    always_comb begin
        spec_rat_d = spec_rat_q;
        if (flush_i) begin
            spec_rat_d = arch_rat_d;
        end else if (fire) begin
            for (int i = 0; i < RENAME_WIDTH; i++)
                if (w[i]) spec_rat_d[rd_i[i]] = new_pdst[i];
        end
    end

    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            for (int i = 0; i < ARCH_REG_NUM; i++) begin
                spec_rat_q[i] <= PW'(i);
                arch_rat_q[i] <= PW'(i);
            end
        end else begin
            spec_rat_q <= spec_rat_d;
            arch_rat_q <= arch_rat_d;
        end
    end

    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            valid_q    <= '0;
            psrc1_q    <= '0;
            psrc2_q    <= '0;
            pdst_q     <= '0;
            old_pdst_q <= '0;
        end else if (fire) begin
            valid_q    <= rename_valid_i;
            psrc1_q    <= psrc1_d;
            psrc2_q    <= psrc2_d;
            pdst_q     <= new_pdst;
            old_pdst_q <= old_pdst_d;
        end else begin
            valid_q    <= '0;
        end
    end

    assign valid_o    = valid_q;
    assign psrc1_o    = psrc1_q;
    assign psrc2_o    = psrc2_q;
    assign pdst_o     = pdst_q;
    assign old_pdst_o = old_pdst_q;

`ifdef RENAME_STALL_CNT_EN
    logic [31:0] stall_cnt_q;
    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n)
            stall_cnt_q <= '0;
        else if (rename_valid_i[0] && !can_alloc_i && !flush_i && !(&stall_cnt_q))
            stall_cnt_q <= stall_cnt_q + 32'd1;
    end
    assign stall_cnt_o = stall_cnt_q;
`else
    assign stall_cnt_o = '0;
`endif

    valid_contiguous_a : assert property (@(posedge clk) disable iff (!a_rst_n)
        ((rename_valid_i & (rename_valid_i + RENAME_WIDTH'(1))) == '0));

endmodule
